// File: rtl/rf_alu_dserial.sv
// Digit-serial ALU (XOR/AND/OR/ADD with operand complement), LSB digit first.
// Two-stage pipeline: stage 1 qualifies digits and applies complements, stage 2 computes and flags.
module rf_alu_dserial #(
  parameter int DW = 4
) (
  input  logic          gclk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_start,
  input  logic          in_end,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          cmpl_x,
  input  logic          cmpl_y,
  input  logic [1:0]    op,
  input  logic          carry_in,
  output logic          out_valid,
  output logic          out_end,
  output logic [DW-1:0] sum,
  output logic          carry_out,
  output logic          overflow,
  output logic          zero,
  output logic          err
);

  localparam int DW1 = DW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [0:0]    state_q, state_d;
  logic [1:0]    ctx_op_q, ctx_op_d;
  logic          ctx_cx_q, ctx_cx_d;
  logic          ctx_cy_q, ctx_cy_d;
  logic          ctx_ci_q, ctx_ci_d;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_start_q, s1_start_d;
  logic          s1_end_q, s1_end_d;
  logic          s1_err_q, s1_err_d;
  logic [DW-1:0] s1_x_q, s1_x_d;
  logic [DW-1:0] s1_y_q, s1_y_d;
  logic [1:0]    s1_op_q, s1_op_d;
  logic          s1_cin_q, s1_cin_d;

  logic          carry_q, carry_d;
  logic          zacc_q, zacc_d;
  logic          out_valid_q, out_valid_d;
  logic          out_end_q, out_end_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          carry_out_q, carry_out_d;
  logic          overflow_q, overflow_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;

  logic          cx_eff, cy_eff, ci_eff;
  logic [1:0]    op_eff;
  logic          c_in;
  logic [DW:0]   add_full;
  logic          c_msb;
  logic [DW-1:0] res;
  logic          is_add;

  // Stage 1: protocol FSM, word context, complemented operands.
  always_comb begin
    state_d    = state_q;
    ctx_op_d   = ctx_op_q;
    ctx_cx_d   = ctx_cx_q;
    ctx_cy_d   = ctx_cy_q;
    ctx_ci_d   = ctx_ci_q;
    s1_valid_d = 1'b0;
    s1_start_d = 1'b0;
    s1_err_d   = 1'b0;

    // The start digit runs on the live context, later digits on the latched copy.
    op_eff = in_start ? op       : ctx_op_q;
    cx_eff = in_start ? cmpl_x   : ctx_cx_q;
    cy_eff = in_start ? cmpl_y   : ctx_cy_q;
    ci_eff = in_start ? carry_in : ctx_ci_q;

    if (in_valid) begin
      if (in_start) begin
        s1_valid_d = 1'b1;
        s1_start_d = 1'b1;
        s1_err_d   = (state_q == ST_BUSY);
        ctx_op_d   = op;
        ctx_cx_d   = cmpl_x;
        ctx_cy_d   = cmpl_y;
        ctx_ci_d   = carry_in;
        state_d    = in_end ? ST_IDLE : ST_BUSY;
      end else if (state_q == ST_BUSY) begin
        s1_valid_d = 1'b1;
        if (in_end) begin
          state_d = ST_IDLE;
        end
      end else begin
        s1_err_d = 1'b1;
      end
    end

    s1_end_d = s1_valid_d & in_end;
    s1_x_d   = x ^ {DW{cx_eff}};
    s1_y_d   = y ^ {DW{cy_eff}};
    s1_op_d  = op_eff;
    s1_cin_d = ci_eff;
  end

  // Stage 2: arithmetic, carry feedback and word flags.
  always_comb begin
    c_in     = s1_start_q ? s1_cin_q : carry_q;
    add_full = DW1'(s1_x_q) + DW1'(s1_y_q) + DW1'(c_in);
    // Carry into the MSB recovered from the MSB sum bit.
    c_msb    = s1_x_q[DW-1] ^ s1_y_q[DW-1] ^ add_full[DW-1];
    is_add   = (s1_op_q == OP_ADD);

    case (s1_op_q)
      OP_XOR:  res = s1_x_q ^ s1_y_q;
      OP_AND:  res = s1_x_q & s1_y_q;
      OP_OR:   res = s1_x_q | s1_y_q;
      default: res = add_full[DW-1:0];
    endcase

    carry_d     = carry_q;
    zacc_d      = zacc_q;
    out_valid_d = 1'b0;
    out_end_d   = 1'b0;
    sum_d       = '0;
    carry_out_d = 1'b0;
    overflow_d  = 1'b0;
    zero_d      = 1'b0;
    err_d       = s1_err_q;

    if (s1_valid_q) begin
      carry_d     = is_add & add_full[DW];
      zacc_d      = (s1_start_q | zacc_q) & (res == '0);
      out_valid_d = 1'b1;
      out_end_d   = s1_end_q;
      sum_d       = res;
      if (s1_end_q) begin
        carry_out_d = is_add & add_full[DW];
        overflow_d  = is_add & (add_full[DW] ^ c_msb);
        zero_d      = zacc_d;
      end
    end
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctx_op_q    <= '0;
      ctx_cx_q    <= 1'b0;
      ctx_cy_q    <= 1'b0;
      ctx_ci_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_start_q  <= 1'b0;
      s1_end_q    <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_op_q     <= '0;
      s1_cin_q    <= 1'b0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_end_q   <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctx_op_q    <= ctx_op_d;
      ctx_cx_q    <= ctx_cx_d;
      ctx_cy_q    <= ctx_cy_d;
      ctx_ci_q    <= ctx_ci_d;
      s1_valid_q  <= s1_valid_d;
      s1_start_q  <= s1_start_d;
      s1_end_q    <= s1_end_d;
      s1_err_q    <= s1_err_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_op_q     <= s1_op_d;
      s1_cin_q    <= s1_cin_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      out_valid_q <= out_valid_d;
      out_end_q   <= out_end_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_end   = out_end_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
